// File: rtl/multicycle_control_fsm.sv
// Main control unit for the multicycle CPU. Steps one instruction at a time
// through fetch/decode/execute/memory/writeback, drives every datapath enable
// and mux select, stalls on mem_ready and parks in TRAP on an illegal opcode.
module multicycle_control_fsm #(
    parameter int unsigned OP_W    = 6,
    parameter int unsigned STATE_W = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [OP_W-1:0]    opcode,
    input  logic               mem_ready,
    output logic               pc_write,
    output logic               pc_write_cond,
    output logic               iord,
    output logic               mem_read,
    output logic               mem_write,
    output logic               ir_write,
    output logic               mem_to_reg,
    output logic               reg_dst,
    output logic               reg_write,
    output logic               alu_src_a,
    output logic [1:0]         alu_src_b,
    output logic [1:0]         alu_op,
    output logic [1:0]         pc_source,
    output logic               halted,
    output logic [STATE_W-1:0] state
);

    localparam logic [OP_W-1:0] OpRtype = OP_W'(6'b000000);
    localparam logic [OP_W-1:0] OpLw    = OP_W'(6'b100011);
    localparam logic [OP_W-1:0] OpSw    = OP_W'(6'b101011);
    localparam logic [OP_W-1:0] OpBeq   = OP_W'(6'b000100);
    localparam logic [OP_W-1:0] OpAddi  = OP_W'(6'b001000);
    localparam logic [OP_W-1:0] OpJ     = OP_W'(6'b000010);

    typedef enum logic [STATE_W-1:0] {
        StFetch  = STATE_W'(0),
        StDecode = STATE_W'(1),
        StMemAdr = STATE_W'(2),
        StMemRd  = STATE_W'(3),
        StMemWb  = STATE_W'(4),
        StMemWr  = STATE_W'(5),
        StExec   = STATE_W'(6),
        StAluWb  = STATE_W'(7),
        StBranch = STATE_W'(8),
        StAddiEx = STATE_W'(9),
        StAddiWb = STATE_W'(10),
        StJump   = STATE_W'(11),
        StTrap   = STATE_W'(15)
    } state_e;

    state_e          state_q, state_d;
    logic [OP_W-1:0] op_q;

    // State register; reset wins over every state, TRAP and stalls included.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StFetch;
        end else begin
            state_q <= state_d;
        end
    end

    // Opcode captured in DECODE so MEMADR ignores later IR changes.
    always_ff @(posedge clk) begin
        if (reset) begin
            op_q <= '0;
        end else if (state_q == StDecode) begin
            op_q <= opcode;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            StFetch:  if (mem_ready) state_d = StDecode;
            StDecode: begin
                case (opcode)
                    OpLw, OpSw: state_d = StMemAdr;
                    OpRtype:    state_d = StExec;
                    OpBeq:      state_d = StBranch;
                    OpAddi:     state_d = StAddiEx;
                    OpJ:        state_d = StJump;
                    default:    state_d = StTrap;
                endcase
            end
            StMemAdr: state_d = (op_q == OpLw) ? StMemRd : StMemWr;
            StMemRd:  if (mem_ready) state_d = StMemWb;
            StMemWb:  state_d = StFetch;
            StMemWr:  if (mem_ready) state_d = StFetch;
            StExec:   state_d = StAluWb;
            StAluWb:  state_d = StFetch;
            StBranch: state_d = StFetch;
            StAddiEx: state_d = StAddiWb;
            StAddiWb: state_d = StFetch;
            StJump:   state_d = StFetch;
            StTrap:   state_d = StTrap;
            // Encodings 12-14 are unreachable; treat as a fault.
            default:  state_d = StTrap;
        endcase
    end

    // Output decode from current state; everything forced low during reset.
    always_comb begin
        pc_write      = 1'b0;
        pc_write_cond = 1'b0;
        iord          = 1'b0;
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        ir_write      = 1'b0;
        mem_to_reg    = 1'b0;
        reg_dst       = 1'b0;
        reg_write     = 1'b0;
        alu_src_a     = 1'b0;
        alu_src_b     = 2'b00;
        alu_op        = 2'b00;
        pc_source     = 2'b00;
        halted        = 1'b0;
        if (!reset) begin
            case (state_q)
                StFetch: begin
                    mem_read  = 1'b1;
                    alu_src_b = 2'b01;
                    // PC+4 and IR load only on the completing cycle, so stalls
                    // never double-increment the PC.
                    ir_write  = mem_ready;
                    pc_write  = mem_ready;
                end
                StDecode: alu_src_b = 2'b11;
                StMemAdr, StAddiEx: begin
                    alu_src_a = 1'b1;
                    alu_src_b = 2'b10;
                end
                StMemRd: begin
                    mem_read = 1'b1;
                    iord     = 1'b1;
                end
                StMemWb: begin
                    reg_write  = 1'b1;
                    mem_to_reg = 1'b1;
                end
                StMemWr: begin
                    mem_write = 1'b1;
                    iord      = 1'b1;
                end
                StExec: begin
                    alu_src_a = 1'b1;
                    alu_op    = 2'b10;
                end
                StAluWb: begin
                    reg_write = 1'b1;
                    reg_dst   = 1'b1;
                end
                StBranch: begin
                    alu_src_a     = 1'b1;
                    alu_op        = 2'b01;
                    pc_write_cond = 1'b1;
                    pc_source     = 2'b01;
                end
                StAddiWb: reg_write = 1'b1;
                StJump: begin
                    pc_write  = 1'b1;
                    pc_source = 2'b10;
                end
                StTrap:  halted = 1'b1;
                default: ;
            endcase
        end
    end

    assign state = reset ? '0 : state_q;

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Directed bench for multicycle_control_fsm: reset, full instruction mix,
// fetch and memory stalls, opcode latching, trap entry and exit.
module tb_multicycle_control_fsm;

    logic       clk = 1'b0;
    logic       reset;
    logic [5:0] opcode;
    logic       mem_ready;
    logic       pc_write, pc_write_cond, iord, mem_read, mem_write, ir_write;
    logic       mem_to_reg, reg_dst, reg_write, alu_src_a, halted;
    logic [1:0] alu_src_b, alu_op, pc_source;
    logic [3:0] state;

    int total = 0;
    int bad   = 0;

    multicycle_control_fsm #(.OP_W(6), .STATE_W(4)) dut (
        .clk(clk), .reset(reset), .opcode(opcode), .mem_ready(mem_ready),
        .pc_write(pc_write), .pc_write_cond(pc_write_cond), .iord(iord),
        .mem_read(mem_read), .mem_write(mem_write), .ir_write(ir_write),
        .mem_to_reg(mem_to_reg), .reg_dst(reg_dst), .reg_write(reg_write),
        .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
        .pc_source(pc_source), .halted(halted), .state(state)
    );

    always #5 clk = ~clk;

    // {pc_write, pc_write_cond, iord, mem_read, mem_write, ir_write, mem_to_reg,
    //  reg_dst, reg_write, alu_src_a, alu_src_b, alu_op, pc_source, halted}
    logic [16:0] ctl;
    assign ctl = {pc_write, pc_write_cond, iord, mem_read, mem_write, ir_write, mem_to_reg,
                  reg_dst, reg_write, alu_src_a, alu_src_b, alu_op, pc_source, halted};

    localparam logic [16:0] C_FETCH  = 17'b1_0_0_1_0_1_0_0_0_0_01_00_00_0;
    localparam logic [16:0] C_FSTALL = 17'b0_0_0_1_0_0_0_0_0_0_01_00_00_0;
    localparam logic [16:0] C_DECODE = 17'b0_0_0_0_0_0_0_0_0_0_11_00_00_0;
    localparam logic [16:0] C_MEMADR = 17'b0_0_0_0_0_0_0_0_0_1_10_00_00_0;
    localparam logic [16:0] C_MEMRD  = 17'b0_0_1_1_0_0_0_0_0_0_00_00_00_0;
    localparam logic [16:0] C_MEMWB  = 17'b0_0_0_0_0_0_1_0_1_0_00_00_00_0;
    localparam logic [16:0] C_MEMWR  = 17'b0_0_1_0_1_0_0_0_0_0_00_00_00_0;
    localparam logic [16:0] C_EXEC   = 17'b0_0_0_0_0_0_0_0_0_1_00_10_00_0;
    localparam logic [16:0] C_ALUWB  = 17'b0_0_0_0_0_0_0_1_1_0_00_00_00_0;
    localparam logic [16:0] C_BRANCH = 17'b0_1_0_0_0_0_0_0_0_1_00_01_01_0;
    localparam logic [16:0] C_ADDIWB = 17'b0_0_0_0_0_0_0_0_1_0_00_00_00_0;
    localparam logic [16:0] C_JUMP   = 17'b1_0_0_0_0_0_0_0_0_0_00_00_10_0;
    localparam logic [16:0] C_TRAP   = 17'b0_0_0_0_0_0_0_0_0_0_00_00_00_1;

    localparam logic [5:0] RTYPE = 6'b000000, LW = 6'b100011, SW = 6'b101011;
    localparam logic [5:0] BEQ = 6'b000100, ADDI = 6'b001000, J = 6'b000010;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; mem_ready = 1'b0; opcode = RTYPE;
        tick(); tick();
        #1;
        total++;
        if (state !== 4'd0) begin bad++; $display("FAIL reset_state got=%0d want=0", state); end
        total++;
        if (ctl !== 17'd0) begin bad++; $display("FAIL reset_ctl got=%b want=0", ctl); end
        reset = 1'b0;
        #1;
        total++;
        if (state !== 4'd0 || ctl !== C_FSTALL) begin
            bad++; $display("FAIL reset_release got st=%0d ctl=%b want st=0 ctl=%b",
                            state, ctl, C_FSTALL);
        end
        mem_ready = 1'b1;
        tick();
        // J brings us back to FETCH in two more edges
        opcode = J;
        tick(); tick();
    endtask

    task automatic test_sequence();
        logic [5:0]  ops [23];
        logic [3:0]  sts [23];
        logic [16:0] cts [23];
        int          pcw;
        ops = '{RTYPE, RTYPE, RTYPE, RTYPE, LW, LW, LW, LW, LW, SW, SW, SW, SW,
                BEQ, BEQ, BEQ, J, J, J, ADDI, ADDI, ADDI, ADDI};
        sts = '{0, 1, 6, 7, 0, 1, 2, 3, 4, 0, 1, 2, 5, 0, 1, 8, 0, 1, 11, 0, 1, 9, 10};
        cts = '{C_FETCH, C_DECODE, C_EXEC, C_ALUWB,
                C_FETCH, C_DECODE, C_MEMADR, C_MEMRD, C_MEMWB,
                C_FETCH, C_DECODE, C_MEMADR, C_MEMWR,
                C_FETCH, C_DECODE, C_BRANCH,
                C_FETCH, C_DECODE, C_JUMP,
                C_FETCH, C_DECODE, C_MEMADR, C_ADDIWB};
        pcw = 0;
        mem_ready = 1'b1;
        for (int i = 0; i < 23; i++) begin
            opcode = ops[i];
            #1;
            total++;
            if (state !== sts[i] || ctl !== cts[i]) begin
                bad++;
                $display("FAIL seq[%0d] got st=%0d ctl=%b want st=%0d ctl=%b",
                         i, state, ctl, sts[i], cts[i]);
            end
            if (state == 4'd0 && pc_write) pcw++;
            tick();
        end
        #1;
        total++;
        if (state !== 4'd0) begin bad++; $display("FAIL seq_end got=%0d want=0", state); end
        total++;
        if (pcw !== 6) begin bad++; $display("FAIL seq_pcw got=%0d want=6", pcw); end
    endtask

    task automatic test_fetch_stall();
        opcode = J;
        for (int i = 0; i < 4; i++) begin
            mem_ready = (i == 3);
            #1;
            total++;
            if (state !== 4'd0 || ctl !== ((i == 3) ? C_FETCH : C_FSTALL)) begin
                bad++;
                $display("FAIL fstall[%0d] got st=%0d ctl=%b want st=0", i, state, ctl);
            end
            tick();
        end
        total++;
        if (state !== 4'd1) begin bad++; $display("FAIL fstall_next got=%0d want=1", state); end
        tick(); tick();
    endtask

    task automatic test_lw_stall();
        int rd_cnt, wb_cnt;
        logic [3:0] exp_st [7];
        logic       rdy    [7];
        exp_st = '{0, 1, 2, 3, 3, 3, 4};
        rdy    = '{1, 1, 1, 0, 0, 1, 1};
        rd_cnt = 0; wb_cnt = 0;
        for (int i = 0; i < 7; i++) begin
            // IR swapped to SW after DECODE must not redirect MEMADR
            opcode    = (i <= 1) ? LW : SW;
            mem_ready = rdy[i];
            #1;
            total++;
            if (state !== exp_st[i]) begin
                bad++; $display("FAIL lw_st[%0d] got=%0d want=%0d", i, state, exp_st[i]);
            end
            if (mem_read && iord) rd_cnt++;
            if (reg_write && mem_to_reg) wb_cnt++;
            total++;
            if ((mem_read && mem_write) || (reg_write && (mem_read || mem_write))) begin
                bad++; $display("FAIL lw_excl[%0d] got ctl=%b want exclusive", i, ctl);
            end
            tick();
        end
        total++;
        if (rd_cnt !== 3) begin bad++; $display("FAIL lw_rd_cnt got=%0d want=3", rd_cnt); end
        total++;
        if (wb_cnt !== 1) begin bad++; $display("FAIL lw_wb_cnt got=%0d want=1", wb_cnt); end
        total++;
        if (state !== 4'd0) begin bad++; $display("FAIL lw_end got=%0d want=0", state); end
    endtask

    task automatic test_reset_mid_memrd();
        mem_ready = 1'b1; opcode = LW;
        tick(); tick(); tick();
        mem_ready = 1'b0;
        #1;
        total++;
        if (state !== 4'd3) begin bad++; $display("FAIL rmid_pre got=%0d want=3", state); end
        reset = 1'b1;
        #1;
        total++;
        if (ctl !== 17'd0) begin bad++; $display("FAIL rmid_comb got=%b want=0", ctl); end
        for (int i = 0; i < 3; i++) begin
            tick();
            total++;
            if (state !== 4'd0 || ctl !== 17'd0) begin
                bad++; $display("FAIL rmid[%0d] got st=%0d ctl=%b want 0", i, state, ctl);
            end
        end
        reset = 1'b0; mem_ready = 1'b1; opcode = J;
        #1;
        total++;
        if (state !== 4'd0 || ctl !== C_FETCH) begin
            bad++; $display("FAIL rmid_resume got st=%0d ctl=%b want st=0 ctl=%b",
                            state, ctl, C_FETCH);
        end
        tick();
        total++;
        if (state !== 4'd1) begin bad++; $display("FAIL rmid_dec got=%0d want=1", state); end
        tick(); tick();
    endtask

    task automatic test_trap(input logic [5:0] op);
        int errs;
        mem_ready = 1'b1; opcode = op;
        tick(); tick();
        errs = 0;
        for (int i = 0; i < 22; i++) begin
            mem_ready = i[0];
            #1;
            if (state !== 4'd15 || ctl !== C_TRAP) errs++;
            tick();
        end
        total++;
        if (errs !== 0) begin
            bad++; $display("FAIL trap_%b got %0d bad cycles (st=%0d) want 0", op, errs, state);
        end
        reset = 1'b1;
        #1;
        total++;
        if (halted !== 1'b0) begin bad++; $display("FAIL trap_rst_halt got=%b want=0", halted); end
        tick();
        reset = 1'b0; mem_ready = 1'b1; opcode = J;
        #1;
        total++;
        if (state !== 4'd0 || halted !== 1'b0) begin
            bad++; $display("FAIL trap_exit got st=%0d halt=%b want st=0 halt=0", state, halted);
        end
        tick(); tick(); tick();
    endtask

    initial begin
        test_reset();
        test_sequence();
        test_fetch_stall();
        test_lw_stall();
        test_reset_mid_memrd();
        test_trap(6'b111111);
        test_trap(6'b000011);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
